// File: rtl/game_sequencer.sv
// Top-level reversi game FSM: walks the datapath through draw, cursor, validate,
// place/flip/score and turn hand-over, one en/go handshake at a time.
module game_sequencer #(
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_enter,
  input  logic       key_right,
  input  logic       key_left,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       go,
  input  logic       validMove,
  input  logic       hasTurn,
  output logic       writeEn,
  output logic       drawBoardEn,
  output logic       drawInitialPiecesEn,
  output logic       moveHighlightEn,
  output logic       checkIfValidMoveEn,
  output logic       placeEn,
  output logic       flipEn,
  output logic       scoreManagerEn,
  output logic       determineHasTurnEn,
  output logic       TurnManagerEn,
  output logic       clearPiecesEn,
  output logic       determineCurrent,
  output logic       determineOpponent,
  output logic       moveRightEn,
  output logic       moveLeftEn,
  output logic       moveUpEn,
  output logic       moveDownEn,
  output logic       game_over,
  output logic       timeout_err,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    RST        = 5'd0,
    DRAW_BOARD = 5'd1,
    DRAW_INIT  = 5'd2,
    DRAW_HL    = 5'd3,
    RELEASE    = 5'd4,
    IDLE       = 5'd5,
    MOVE       = 5'd6,
    MOVE_HL    = 5'd7,
    CHECK      = 5'd8,
    PLACE      = 5'd9,
    FLIP       = 5'd10,
    SCORE      = 5'd11,
    TURN       = 5'd12,
    HAS_CUR    = 5'd13,
    HAS_OPP    = 5'd14,
    PASS_TURN  = 5'd15,
    OVER       = 5'd16,
    CLEAR      = 5'd17
  } stateT;

  // Timeout fires on the cycle whose count would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  stateT                state, stateNext;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 keyArmed, keyArmedNext;
  logic                 keyAny, isHandshake, timeoutHit, advance, moveOk, turnOk;
  logic                 dirRight, dirLeft, dirUp, dirDown;

  logic writeEnNxt, drawBoardEnNxt, drawInitialPiecesEnNxt, moveHighlightEnNxt;
  logic checkIfValidMoveEnNxt, placeEnNxt, flipEnNxt, scoreManagerEnNxt;
  logic determineHasTurnEnNxt, turnManagerEnNxt, clearPiecesEnNxt;
  logic determineCurrentNxt, determineOpponentNxt;
  logic moveRightEnNxt, moveLeftEnNxt, moveUpEnNxt, moveDownEnNxt, gameOverNxt;

  assign keyAny      = key_enter | key_right | key_left | key_up | key_down;
  assign isHandshake = state inside {DRAW_BOARD, DRAW_INIT, DRAW_HL, MOVE_HL, CHECK, PLACE,
                                     FLIP, SCORE, TURN, PASS_TURN, HAS_CUR, HAS_OPP, CLEAR};
  assign timeoutHit  = isHandshake && !go && (watchdog == WD_LAST);
  assign advance     = go || timeoutHit;
  assign moveOk      = go && validMove;
  assign turnOk      = go && hasTurn;
  assign dirRight    = key_right;
  assign dirLeft     = !key_right && key_left;
  assign dirUp       = !key_right && !key_left && key_up;
  assign dirDown     = !key_right && !key_left && !key_up && key_down;
  assign state_dbg   = state;

  // State, watchdog, key arming and the registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state               <= RST;
      watchdog            <= '0;
      keyArmed            <= 1'b0;
      timeout_err         <= 1'b0;
      writeEn             <= 1'b0;
      drawBoardEn         <= 1'b0;
      drawInitialPiecesEn <= 1'b0;
      moveHighlightEn     <= 1'b0;
      checkIfValidMoveEn  <= 1'b0;
      placeEn             <= 1'b0;
      flipEn              <= 1'b0;
      scoreManagerEn      <= 1'b0;
      determineHasTurnEn  <= 1'b0;
      TurnManagerEn       <= 1'b0;
      clearPiecesEn       <= 1'b0;
      determineCurrent    <= 1'b0;
      determineOpponent   <= 1'b0;
      moveRightEn         <= 1'b0;
      moveLeftEn          <= 1'b0;
      moveUpEn            <= 1'b0;
      moveDownEn          <= 1'b0;
      game_over           <= 1'b0;
    end else begin
      state               <= stateNext;
      watchdog            <= (advance || !isHandshake) ? '0 : watchdog + 1'b1;
      keyArmed            <= keyArmedNext;
      timeout_err         <= timeout_err | timeoutHit;
      writeEn             <= writeEnNxt;
      drawBoardEn         <= drawBoardEnNxt;
      drawInitialPiecesEn <= drawInitialPiecesEnNxt;
      moveHighlightEn     <= moveHighlightEnNxt;
      checkIfValidMoveEn  <= checkIfValidMoveEnNxt;
      placeEn             <= placeEnNxt;
      flipEn              <= flipEnNxt;
      scoreManagerEn      <= scoreManagerEnNxt;
      determineHasTurnEn  <= determineHasTurnEnNxt;
      TurnManagerEn       <= turnManagerEnNxt;
      clearPiecesEn       <= clearPiecesEnNxt;
      determineCurrent    <= determineCurrentNxt;
      determineOpponent   <= determineOpponentNxt;
      moveRightEn         <= moveRightEnNxt;
      moveLeftEn          <= moveLeftEnNxt;
      moveUpEn            <= moveUpEnNxt;
      moveDownEn          <= moveDownEnNxt;
      game_over           <= gameOverNxt;
    end
  end

  // Next state; a key only acts once it has been seen fully released.
  always_comb begin
    stateNext    = state;
    keyArmedNext = keyArmed;
    case (state)
      RST:        stateNext = DRAW_BOARD;
      DRAW_BOARD: if (advance) stateNext = DRAW_INIT;
      DRAW_INIT:  if (advance) stateNext = DRAW_HL;
      DRAW_HL:    if (advance) stateNext = RELEASE;
      RELEASE: begin
        if (!keyAny) begin
          stateNext    = IDLE;
          keyArmedNext = 1'b1;
        end
      end
      IDLE: begin
        if (keyArmed && keyAny) begin
          keyArmedNext = 1'b0;
          stateNext    = key_enter ? CHECK : MOVE;
        end
      end
      MOVE:       stateNext = MOVE_HL;
      MOVE_HL:    if (advance) stateNext = RELEASE;
      CHECK:      if (advance) stateNext = moveOk ? PLACE : RELEASE;
      PLACE:      if (advance) stateNext = FLIP;
      FLIP:       if (advance) stateNext = SCORE;
      SCORE:      if (advance) stateNext = TURN;
      TURN:       if (advance) stateNext = HAS_CUR;
      HAS_CUR:    if (advance) stateNext = turnOk ? MOVE_HL : HAS_OPP;
      HAS_OPP:    if (advance) stateNext = turnOk ? PASS_TURN : OVER;
      PASS_TURN:  if (advance) stateNext = MOVE_HL;
      OVER: begin
        if (keyArmed && key_enter) begin
          keyArmedNext = 1'b0;
          stateNext    = CLEAR;
        end else if (!keyArmed && !keyAny) begin
          keyArmedNext = 1'b1;
        end
      end
      CLEAR:      if (advance) stateNext = DRAW_INIT;
      default:    stateNext = RST;
    endcase
  end

  // Outputs decoded from the upcoming state so they line up with state_dbg.
  always_comb begin
    writeEnNxt             = 1'b0;
    drawBoardEnNxt         = 1'b0;
    drawInitialPiecesEnNxt = 1'b0;
    moveHighlightEnNxt     = 1'b0;
    checkIfValidMoveEnNxt  = 1'b0;
    placeEnNxt             = 1'b0;
    flipEnNxt              = 1'b0;
    scoreManagerEnNxt      = 1'b0;
    determineHasTurnEnNxt  = 1'b0;
    turnManagerEnNxt       = 1'b0;
    clearPiecesEnNxt       = 1'b0;
    determineCurrentNxt    = 1'b0;
    determineOpponentNxt   = 1'b0;
    moveRightEnNxt         = 1'b0;
    moveLeftEnNxt          = 1'b0;
    moveUpEnNxt            = 1'b0;
    moveDownEnNxt          = 1'b0;
    gameOverNxt            = 1'b0;
    case (stateNext)
      DRAW_BOARD: begin
        drawBoardEnNxt = 1'b1;
        writeEnNxt     = 1'b1;
      end
      DRAW_INIT: begin
        drawInitialPiecesEnNxt = 1'b1;
        writeEnNxt             = 1'b1;
      end
      DRAW_HL, MOVE_HL: begin
        moveHighlightEnNxt = 1'b1;
        writeEnNxt         = 1'b1;
      end
      MOVE: begin
        moveRightEnNxt = dirRight;
        moveLeftEnNxt  = dirLeft;
        moveUpEnNxt    = dirUp;
        moveDownEnNxt  = dirDown;
      end
      CHECK: checkIfValidMoveEnNxt = 1'b1;
      PLACE: begin
        placeEnNxt = 1'b1;
        writeEnNxt = 1'b1;
      end
      FLIP: begin
        flipEnNxt  = 1'b1;
        writeEnNxt = 1'b1;
      end
      SCORE:           scoreManagerEnNxt = 1'b1;
      TURN, PASS_TURN: turnManagerEnNxt  = 1'b1;
      HAS_CUR: begin
        determineHasTurnEnNxt = 1'b1;
        determineCurrentNxt   = 1'b1;
      end
      HAS_OPP: begin
        determineHasTurnEnNxt = 1'b1;
        determineOpponentNxt  = 1'b1;
      end
      OVER: gameOverNxt = 1'b1;
      CLEAR: begin
        clearPiecesEnNxt = 1'b1;
        writeEnNxt       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: expected state codes are queued as stimulus
// is driven and matched against every state_dbg change.
module tb_game_sequencer;

  localparam int TW = 4;
  localparam int EN_DB = 0, EN_DI = 1, EN_HL = 2, EN_CK = 3, EN_PL = 4;
  localparam int EN_FL = 5, EN_SC = 6, EN_DT = 7, EN_TM = 8, EN_CL = 9;

  typedef struct {
    int         idx;
    logic       vm;
    logic       ht;
    logic       wr;
    logic       cur;
    logic       opp;
    logic [4:0] nxt;
  } opT;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic key_enter = 1'b0, key_right = 1'b0, key_left = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic go = 1'b0, validMove = 1'b0, hasTurn = 1'b0;
  logic writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn;
  logic placeEn, flipEn, scoreManagerEn, determineHasTurnEn, TurnManagerEn, clearPiecesEn;
  logic determineCurrent, determineOpponent;
  logic moveRightEn, moveLeftEn, moveUpEn, moveDownEn, game_over, timeout_err;
  logic [4:0] state_dbg;
  logic [9:0] ens;
  logic [3:0] moves;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] expQ[$];
  logic       monOn = 1'b0;
  logic [4:0] prevState = 5'd0;
  logic [4:0] expState;
  int         moveCount = 0;
  int         placeFlipCount = 0;

  game_sequencer #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .resetn(resetn),
    .key_enter(key_enter), .key_right(key_right), .key_left(key_left),
    .key_up(key_up), .key_down(key_down),
    .go(go), .validMove(validMove), .hasTurn(hasTurn),
    .writeEn(writeEn), .drawBoardEn(drawBoardEn), .drawInitialPiecesEn(drawInitialPiecesEn),
    .moveHighlightEn(moveHighlightEn), .checkIfValidMoveEn(checkIfValidMoveEn),
    .placeEn(placeEn), .flipEn(flipEn), .scoreManagerEn(scoreManagerEn),
    .determineHasTurnEn(determineHasTurnEn), .TurnManagerEn(TurnManagerEn),
    .clearPiecesEn(clearPiecesEn), .determineCurrent(determineCurrent),
    .determineOpponent(determineOpponent), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .game_over(game_over),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ens = {clearPiecesEn, TurnManagerEn, determineHasTurnEn, scoreManagerEn, flipEn,
                placeEn, checkIfValidMoveEn, moveHighlightEn, drawInitialPiecesEn, drawBoardEn};
  assign moves = {moveDownEn, moveUpEn, moveLeftEn, moveRightEn};

  // Every state change must match the oldest queued expectation.
  always @(negedge clk) begin
    if (monOn && state_dbg !== prevState) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL stateSeq: moved to %0d, nothing expected", state_dbg);
      end else begin
        expState = expQ.pop_front();
        if (state_dbg !== expState) begin
          errors++;
          $display("[TB] FAIL stateSeq: got %0d, expected %0d", state_dbg, expState);
        end
      end
    end
    if (moves != 4'b0000) moveCount++;
    if (placeEn || flipEn) placeFlipCount++;
    prevState = state_dbg;
  end

  // Serves one handshake: answers go on the hold-th cycle and reports what was seen.
  task automatic applyStimulus(input int idx, input int hold, input logic vm, input logic ht,
                               output int onCycles, output int wrCycles,
                               output int curCycles, output int oppCycles);
    onCycles = 0; wrCycles = 0; curCycles = 0; oppCycles = 0;
    for (int c = 1; c <= hold; c++) begin
      if (ens == (10'd1 << idx)) onCycles++;
      if (writeEn) wrCycles++;
      if (determineCurrent) curCycles++;
      if (determineOpponent) oppCycles++;
      if (c == hold) begin
        go = 1'b1; validMove = vm; hasTurn = ht;
      end
      @(negedge clk);
    end
    go = 1'b0; validMove = 1'b0; hasTurn = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== 5'd0) begin
      errors++; $display("[TB] FAIL resetState: got %0d, expected 0", state_dbg);
    end
    checks++;
    if (ens !== 10'd0 || moves !== 4'd0) begin
      errors++; $display("[TB] FAIL resetEnables: ens %b moves %b, expected zeros", ens, moves);
    end
    checks++;
    if ({writeEn, game_over, timeout_err, determineCurrent, determineOpponent} !== 5'b0) begin
      errors++; $display("[TB] FAIL resetFlags: got %b, expected 00000",
                         {writeEn, game_over, timeout_err, determineCurrent, determineOpponent});
    end
    monOn = 1'b1;
    expQ.push_back(5'd1);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bringup();
    opT ops[3];
    int onC, wrC, curC, oppC;
    ops[0] = '{EN_DB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2};
    ops[1] = '{EN_DI, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    ops[2] = '{EN_HL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4};
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(ops[i].nxt);
      applyStimulus(ops[i].idx, 10, ops[i].vm, ops[i].ht, onC, wrC, curC, oppC);
      checks++;
      if (onC !== 10) begin
        errors++; $display("[TB] FAIL bringupEnable step %0d: %0d cycles, expected 10", i, onC);
      end
      checks++;
      if (wrC !== 10) begin
        errors++; $display("[TB] FAIL bringupWrite step %0d: %0d cycles, expected 10", i, wrC);
      end
    end
    checks++;
    if (state_dbg !== 5'd4 || ens !== 10'd0 || writeEn !== 1'b0) begin
      errors++; $display("[TB] FAIL bringupRelease: state %0d ens %b wr %b, expected 4/0/0",
                         state_dbg, ens, writeEn);
    end
    expQ.push_back(5'd5);
    @(negedge clk);
    checks++;
    if (state_dbg !== 5'd5) begin
      errors++; $display("[TB] FAIL bringupIdle: got %0d, expected 5", state_dbg);
    end
  endtask

  task automatic test_move_hold();
    int onC, wrC, curC, oppC, m0;
    m0 = moveCount;
    for (int press = 0; press < 2; press++) begin
      key_right = 1'b1;
      expQ.push_back(5'd6);
      expQ.push_back(5'd7);
      @(negedge clk);
      checks++;
      if (moves !== 4'b0001 || ens !== 10'd0) begin
        errors++; $display("[TB] FAIL moveStep press %0d: moves %b ens %b, expected 0001/0",
                           press, moves, ens);
      end
      @(negedge clk);
      expQ.push_back(5'd4);
      applyStimulus(EN_HL, 5, 1'b0, 1'b0, onC, wrC, curC, oppC);
      checks++;
      if (onC !== 5 || wrC !== 5) begin
        errors++; $display("[TB] FAIL moveHighlight press %0d: on %0d wr %0d, expected 5/5",
                           press, onC, wrC);
      end
      if (press == 0) begin
        repeat (43) @(negedge clk);
        checks++;
        if (moveCount - m0 !== 1 || state_dbg !== 5'd4) begin
          errors++; $display("[TB] FAIL moveHeld: steps %0d state %0d, expected 1/4",
                             moveCount - m0, state_dbg);
        end
      end
      key_right = 1'b0;
      expQ.push_back(5'd5);
      @(negedge clk);
    end
    checks++;
    if (moveCount - m0 !== 2 || state_dbg !== 5'd5) begin
      errors++; $display("[TB] FAIL moveRepress: steps %0d state %0d, expected 2/5",
                         moveCount - m0, state_dbg);
    end
  endtask

  task automatic test_priority_invalid();
    int onC, wrC, curC, oppC, mc, pf;
    mc = moveCount;
    pf = placeFlipCount;
    key_enter = 1'b1;
    key_left  = 1'b1;
    expQ.push_back(5'd8);
    @(negedge clk);
    expQ.push_back(5'd4);
    applyStimulus(EN_CK, 4, 1'b0, 1'b0, onC, wrC, curC, oppC);
    checks++;
    if (onC !== 4 || wrC !== 0) begin
      errors++; $display("[TB] FAIL priorityCheck: on %0d wr %0d, expected 4/0", onC, wrC);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (state_dbg !== 5'd4) begin
      errors++; $display("[TB] FAIL invalidRelease: got %0d, expected 4", state_dbg);
    end
    key_enter = 1'b0;
    key_left  = 1'b0;
    expQ.push_back(5'd5);
    @(negedge clk);
    checks++;
    if (moveCount !== mc || placeFlipCount !== pf) begin
      errors++; $display("[TB] FAIL priorityNoSideEffect: moves %0d place/flip %0d, expected 0/0",
                         moveCount - mc, placeFlipCount - pf);
    end
  endtask

  task automatic test_valid_chain();
    opT ops[7];
    int onC, wrC, curC, oppC;
    ops[0] = '{EN_CK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9};
    ops[1] = '{EN_PL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10};
    ops[2] = '{EN_FL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11};
    ops[3] = '{EN_SC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12};
    ops[4] = '{EN_TM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13};
    ops[5] = '{EN_DT, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7};
    ops[6] = '{EN_HL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4};
    key_enter = 1'b1;
    expQ.push_back(5'd8);
    @(negedge clk);
    key_enter = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expQ.push_back(ops[i].nxt);
      applyStimulus(ops[i].idx, 3, ops[i].vm, ops[i].ht, onC, wrC, curC, oppC);
      checks++;
      if (onC !== 3 || wrC !== (ops[i].wr ? 3 : 0)) begin
        errors++; $display("[TB] FAIL chainEnable step %0d: on %0d wr %0d, expected 3/%0d",
                           i, onC, wrC, ops[i].wr ? 3 : 0);
      end
      checks++;
      if (curC !== (ops[i].cur ? 3 : 0) || oppC !== (ops[i].opp ? 3 : 0)) begin
        errors++; $display("[TB] FAIL chainQualifier step %0d: cur %0d opp %0d", i, curC, oppC);
      end
    end
    expQ.push_back(5'd5);
    @(negedge clk);
    checks++;
    if (state_dbg !== 5'd5) begin
      errors++; $display("[TB] FAIL chainIdle: got %0d, expected 5", state_dbg);
    end
  endtask

  task automatic test_pass_gameover();
    opT ops[9];
    int onC, wrC, curC, oppC, n;
    for (int r = 0; r < 2; r++) begin
      ops[0] = '{EN_CK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9};
      ops[1] = '{EN_PL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10};
      ops[2] = '{EN_FL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11};
      ops[3] = '{EN_SC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12};
      ops[4] = '{EN_TM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13};
      ops[5] = '{EN_DT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14};
      if (r == 0) begin
        ops[6] = '{EN_DT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd15};
        ops[7] = '{EN_TM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7};
        ops[8] = '{EN_HL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4};
        n = 9;
      end else begin
        ops[6] = '{EN_DT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16};
        n = 7;
      end
      key_enter = 1'b1;
      expQ.push_back(5'd8);
      @(negedge clk);
      key_enter = 1'b0;
      for (int i = 0; i < n; i++) begin
        expQ.push_back(ops[i].nxt);
        applyStimulus(ops[i].idx, 2, ops[i].vm, ops[i].ht, onC, wrC, curC, oppC);
        checks++;
        if (onC !== 2 || wrC !== (ops[i].wr ? 2 : 0)) begin
          errors++; $display("[TB] FAIL passEnable round %0d step %0d: on %0d wr %0d",
                             r, i, onC, wrC);
        end
        checks++;
        if (curC !== (ops[i].cur ? 2 : 0) || oppC !== (ops[i].opp ? 2 : 0)) begin
          errors++; $display("[TB] FAIL passQualifier round %0d step %0d: cur %0d opp %0d",
                             r, i, curC, oppC);
        end
      end
      if (r == 0) begin
        expQ.push_back(5'd5);
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== 5'd16 || game_over !== 1'b1 || ens !== 10'd0) begin
      errors++; $display("[TB] FAIL gameOver: state %0d over %b ens %b, expected 16/1/0",
                         state_dbg, game_over, ens);
    end
    key_enter = 1'b1;
    expQ.push_back(5'd17);
    @(negedge clk);
    key_enter = 1'b0;
    ops[0] = '{EN_CL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2};
    ops[1] = '{EN_DI, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    ops[2] = '{EN_HL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (game_over !== 1'b0) begin
        errors++; $display("[TB] FAIL restartOver step %0d: game_over %b, expected 0", i, game_over);
      end
      expQ.push_back(ops[i].nxt);
      applyStimulus(ops[i].idx, 2, 1'b0, 1'b0, onC, wrC, curC, oppC);
      checks++;
      if (onC !== 2 || wrC !== 2) begin
        errors++; $display("[TB] FAIL restartEnable step %0d: on %0d wr %0d, expected 2/2",
                           i, onC, wrC);
      end
    end
    expQ.push_back(5'd5);
    @(negedge clk);
  endtask

  task automatic test_watchdog_abort();
    int onC, wrC, curC, oppC, cyc, flipCycles, early;
    key_enter = 1'b1;
    expQ.push_back(5'd8);
    @(negedge clk);
    key_enter = 1'b0;
    expQ.push_back(5'd9);
    applyStimulus(EN_CK, 3, 1'b1, 1'b0, onC, wrC, curC, oppC);
    expQ.push_back(5'd10);
    applyStimulus(EN_PL, 3, 1'b0, 1'b0, onC, wrC, curC, oppC);
    checks++;
    if (onC !== 3) begin
      errors++; $display("[TB] FAIL watchdogPlace: on %0d, expected 3", onC);
    end
    expQ.push_back(5'd11);
    cyc = 0; flipCycles = 0; early = 0;
    while (state_dbg === 5'd10 && cyc < 40) begin
      cyc++;
      if (flipEn) flipCycles++;
      if (timeout_err) early++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 15 || flipCycles !== 15 || early !== 0) begin
      errors++; $display("[TB] FAIL watchdogCycles: in FLIP %0d flipEn %0d early %0d, expected 15/15/0",
                         cyc, flipCycles, early);
    end
    checks++;
    if (timeout_err !== 1'b1 || state_dbg !== 5'd11 || ens !== (10'd1 << EN_SC)) begin
      errors++; $display("[TB] FAIL timeoutAdvance: err %b state %0d ens %b, expected 1/11/score",
                         timeout_err, state_dbg, ens);
    end
    expQ.push_back(5'd0);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 5'd0 || ens !== 10'd0 || timeout_err !== 1'b0 || writeEn !== 1'b0) begin
      errors++; $display("[TB] FAIL abort: state %0d ens %b err %b wr %b, expected all 0",
                         state_dbg, ens, timeout_err, writeEn);
    end
    expQ.push_back(5'd1);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 5'd1 || ens !== (10'd1 << EN_DB)) begin
      errors++; $display("[TB] FAIL reRelease: state %0d ens %b, expected 1/drawBoard",
                         state_dbg, ens);
    end
  endtask

  initial begin
    $display("[TB] game_sequencer bench starting");
    test_reset();
    test_bringup();
    test_move_hold();
    test_priority_invalid();
    test_valid_chain();
    test_pass_gameover();
    test_watchdog_abort();
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("[TB] FAIL pendingTransitions: %0d expected states never seen", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
